// File: rtl/fetch_unit_pipelined.sv
// Front-end fetch stage: one outstanding icache block request, JAL predecode,
// and a circular fetch queue feeding the instruction buffer.
module fetch_unit_pipelined #(
    parameter int          FETCH_WIDTH = 4,
    parameter int          FQ_DEPTH    = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             redirect_valid,
    input  logic [31:0]                      redirect_pc,
    output logic                             icache_req_valid,
    input  logic                             icache_req_ready,
    output logic [31:0]                      icache_req_addr,
    input  logic                             icache_resp_valid,
    input  logic [FETCH_WIDTH*32-1:0]        icache_resp_data,
    output logic                             fb_valid,
    input  logic                             fb_ready,
    output logic [FETCH_WIDTH*64-1:0]        fb_insts,
    output logic [FETCH_WIDTH-1:0]           fb_insts_valid,
    output logic [$clog2(FQ_DEPTH+1)-1:0]    fq_count
);
    localparam int          PW        = $clog2(FQ_DEPTH);
    localparam int          CW        = $clog2(FQ_DEPTH+1);
    localparam logic [31:0] BLK_BYTES = 32'(FETCH_WIDTH*4);
    localparam logic [31:0] LANE_MASK = 32'(FETCH_WIDTH-1);
    localparam logic [6:0]  OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             pc_q, pc_d;
    logic                    req_valid_q, req_valid_d;
    logic [PW-1:0]           head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]           count_q, count_d;

    logic [FETCH_WIDTH*32-1:0] fq_data_q [FQ_DEPTH];
    logic [31:0]               fq_base_q [FQ_DEPTH];
    logic [FETCH_WIDTH-1:0]    fq_mask_q [FQ_DEPTH];

    logic [31:0]             pc_aligned, lane_off, next_pc;
    logic [FETCH_WIDTH-1:0]  lane_valid;
    logic                    handshake, enq, deq;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FQ_DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    assign pc_aligned       = pc_q & ~(BLK_BYTES - 32'd1);
    assign lane_off         = (pc_q >> 2) & LANE_MASK;
    assign icache_req_valid = req_valid_q;
    assign icache_req_addr  = pc_aligned;

    // Lanes before the entry offset and after the first taken JAL are masked off.
    always_comb begin : predecode
        logic        blocked;
        logic [31:0] imm;
        blocked    = 1'b0;
        imm        = '0;
        lane_valid = '0;
        next_pc    = pc_aligned + BLK_BYTES;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            imm = {{12{icache_resp_data[32*i+31]}}, icache_resp_data[32*i+12 +: 8],
                   icache_resp_data[32*i+20], icache_resp_data[32*i+21 +: 10], 1'b0};
            if (32'(i) >= lane_off && !blocked) begin
                lane_valid[i] = 1'b1;
                if (icache_resp_data[32*i +: 7] == OP_JAL) begin
                    blocked = 1'b1;
                    next_pc = pc_aligned + 32'(4*i) + imm;
                end
            end
        end
    end

    // req_valid_q is only ever set alongside S_REQ, so it doubles as the state qualifier.
    assign handshake = req_valid_q & icache_req_ready;
    assign enq       = (state_q == S_WAIT) && icache_resp_valid && !redirect_valid;
    assign deq       = fb_valid && fb_ready && !redirect_valid;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            S_REQ:          if (handshake) state_d = S_WAIT;
            S_WAIT, S_DROP: if (icache_resp_valid) state_d = S_REQ;
            default:        state_d = S_REQ;
        endcase
        if (enq) begin
            pc_d   = next_pc;
            tail_d = ptr_inc(tail_q);
        end
        if (deq) head_d = ptr_inc(head_q);
        count_d = count_q + CW'(enq) - CW'(deq);
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            if (state_q == S_REQ) state_d = handshake ? S_DROP : S_REQ;
            else                  state_d = icache_resp_valid ? S_REQ : S_DROP;
        end
        req_valid_d = (state_d == S_REQ) && (count_d < CW'(FQ_DEPTH));
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_valid_q <= req_valid_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_n && enq) begin
            fq_data_q[tail_q] <= icache_resp_data;
            fq_base_q[tail_q] <= pc_aligned;
            fq_mask_q[tail_q] <= lane_valid;
        end
    end

    assign fb_valid       = (count_q != '0);
    assign fq_count       = count_q;
    assign fb_insts_valid = fb_valid ? fq_mask_q[head_q] : '0;

    always_comb begin
        fb_insts = '0;
        for (int i = 0; i < FETCH_WIDTH; i++)
            fb_insts[64*i +: 64] = {fq_data_q[head_q][32*i +: 32], fq_base_q[head_q] + 32'(4*i)};
    end
endmodule

// File: doc/fetch_unit_pipelined.md
Name: fetch_unit_pipelined

Overview:
Parametrised front-end fetch stage. It issues aligned fetch-block requests to the icache over a valid/ready handshake and accepts the response a variable number of cycles later. Each response is predecoded for JAL and written into a small fetch queue. The queue drives the instruction buffer with a valid/ready handshake. Redirects from the backend or branch predictor flush the queue and discard any in-flight icache response using a DROP state.

Parameters:
FETCH_WIDTH, 4, instructions per fetch block; power of two, 1..8.
FQ_DEPTH, 4, fetch-queue entries (bundles); at least 2.
RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
clock  input  1  system clock
reset_n  input  1  synchronous active-low reset
redirect_valid  input  1  redirect request; highest priority
redirect_pc  input  32  redirect target (word aligned)
icache_req_valid  output  1  fetch request valid
icache_req_ready  input  1  icache accepts request
icache_req_addr  output  32  block-aligned address: pc with low log2(FETCH_WIDTH*4) bits cleared
icache_resp_valid  input  1  response data valid, one-cycle pulse
icache_resp_data  input  FETCH_WIDTH*32  lane i = bits [32i+31:32i]
fb_valid  output  1  head bundle valid
fb_ready  input  1  instruction buffer accepts the head bundle
fb_insts  output  FETCH_WIDTH x fb_entry_t  per-lane {inst, pc}
fb_insts_valid  output  FETCH_WIDTH  per-lane valid mask of the head bundle
fq_count  output  $clog2(FQ_DEPTH+1)  queue occupancy

Behaviour:
- Reset (reset_n low at a clock edge):
  - pc = RESET_PC, state = REQ, queue empty.
  - icache_req_valid = 0, fb_valid = 0, fq_count = 0, fb_insts_valid = 0.
  - Reset mid-operation abandons any outstanding request.
- States:
  - REQ: no request outstanding. icache_req_valid = (fq_count < FQ_DEPTH). This is a registered condition and has no combinational path from redirect_valid. On handshake (valid & ready), go to WAIT.
  - WAIT: one request outstanding, icache_req_valid = 0. On icache_resp_valid, enqueue the bundle, update pc to the predicted next pc, go to REQ.
  - DROP: a stale request is outstanding. On icache_resp_valid, discard the data and go to REQ.
- Redirect (redirect_valid = 1) at a clock edge:
  - pc <= redirect_pc; queue flushed (count 0). A same-cycle dequeue or enqueue is ignored.
  - Next state:
    - REQ with no handshake this cycle: REQ.
    - REQ with a handshake this cycle: DROP.
    - WAIT: DROP. A response arriving in the same cycle is also discarded and the state goes to REQ.
    - DROP: stays DROP unless a response arrives in the same cycle, in which case REQ.
- icache_resp_valid in REQ is a protocol error: ignore it and fire a bench assertion.
- At most one request is outstanding. A request is issued only when a free queue slot exists, so an enqueue never overflows. Enqueue and dequeue may occur in the same cycle.
- Lane predecode (combinational on icache_resp_data):
  - off = pc[log2(FETCH_WIDTH)+1:2].
  - lane pc = aligned pc + 4i.
  - is_jal[i] = (inst[6:0] == 7'b1101111).
  - valid[i] = (i >= off) and no lane j with off <= j < i has is_jal[j].
- Next pc:
  - If any valid lane is JAL, next pc = that lane's pc + sign-extended J-immediate of the lowest such lane, mod 2^32.
  - Otherwise next pc = aligned pc + FETCH_WIDTH*4, wrapping at 2^32.
- Enqueue latency: the bundle is written at the edge where icache_resp_valid is high. fb_valid is asserted from the following cycle, so best-case request-to-fb_valid is 2 cycles with a 1-cycle icache.
- Queue:
  - Circular, FQ_DEPTH entries, head and tail pointers with wrap-around.
  - fb_* outputs come directly from the head entry (registered).
  - Pop on fb_valid & fb_ready.
  - fb_insts is don't-care when fb_valid = 0.

Test Plan:
- FETCH_WIDTH=4, RESET_PC=0, ready=1, 1-cycle icache returning 0x00000013 x4 -> req addr 0x00, then bundle pcs 0,4,8,C with valid 4'b1111; next req addr 0x10, fb_valid asserted 2 cycles after the first request.
- Redirect to 0x28 while in REQ -> next req addr 0x20; bundle valid 4'b1100, pcs 0x28 and 0x2C.
- Fetch at 0x0 with lane1 = 0x0100006F (jal x0,+16) -> valid 4'b0011, next req addr 0x10, next bundle (pc 0x14) valid 4'b1110.
- Redirect to 0x100 while in WAIT, response 3 cycles later -> response dropped, fb_valid stays 0, fq_count = 0; next req addr 0x100 only after the drop.
- FQ_DEPTH=4, fb_ready=0 -> 4 bundles enqueued, fq_count = 4, icache_req_valid = 0; one pop -> icache_req_valid = 1 the next cycle.
- reset_n low for 1 cycle during WAIT with the queue at 2 -> fq_count = 0, fb_valid = 0, req_valid = 0 in the reset cycle; req addr = RESET_PC afterwards.
